// File: rtl/obi_bank_xbar.sv
// rtl/obi_bank_xbar.sv - NMASTERS x N_BANKS OBI crossbar with per-bank round-robin and in-order response routing
// Optional per-bank conflict counters are built when MOCHILA_XBAR_PERF_EN is defined.

package obi_bank_xbar_pkg;
   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;
endpackage

module obi_bank_xbar
   import obi_bank_xbar_pkg::*;
#(
   parameter int unsigned NMASTERS        = 4,
   parameter int unsigned N_BANKS         = 2,
   parameter logic [31:0] BANK_SIZE       = 32'h8000,
   parameter bit          INTERLEAVED     = 1'b0,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  obi_req_t    master_req_i   [NMASTERS],
   output obi_resp_t   master_resp_o  [NMASTERS],
   output obi_req_t    ram_req_o      [N_BANKS],
   input  obi_resp_t   ram_resp_i     [N_BANKS],
   output logic        protocol_err_o,
   output logic [31:0] conflict_cnt_o [N_BANKS]
);
   localparam int unsigned BW       = $clog2(N_BANKS);
   localparam int unsigned MW       = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
   localparam int unsigned OW       = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned FD       = NMASTERS * MAX_OUTSTANDING;
   localparam int unsigned FW       = (FD > 1) ? $clog2(FD) : 1;
   localparam int unsigned BANK_LSB = INTERLEAVED ? 2 : $clog2(BANK_SIZE);

   logic [BW-1:0]       sel       [NMASTERS];
   logic [NMASTERS-1:0] elig      [N_BANKS];
   logic [MW-1:0]       winner    [N_BANKS];
   logic [MW-1:0]       head      [N_BANKS];
   logic [N_BANKS-1:0]  bank_req, bank_hs, bank_rv, fifo_empty;
   logic [NMASTERS-1:0] m_gnt, m_rv;

   logic [OW-1:0]       out_cnt   [NMASTERS];
   logic [BW-1:0]       last_bank [NMASTERS];
   logic [MW-1:0]       ptr       [N_BANKS];
   logic [N_BANKS-1:0]  lock_valid;
   logic [MW-1:0]       lock_idx  [N_BANKS];
   logic [MW-1:0]       fifo_mem  [N_BANKS][FD];
   logic [FW-1:0]       wr_ptr    [N_BANKS];
   logic [FW-1:0]       rd_ptr    [N_BANKS];
   logic [FW:0]         fifo_cnt  [N_BANKS];

   // A master with responses pending may only target the bank it already talks to.
   always_comb begin
      for (int m = 0; m < NMASTERS; m++) begin
         sel[m] = master_req_i[m].addr[BANK_LSB +: BW];
      end
      for (int b = 0; b < N_BANKS; b++) begin
         elig[b] = '0;
         for (int m = 0; m < NMASTERS; m++) begin
            elig[b][m] = master_req_i[m].req && (sel[m] == BW'(b)) &&
                         (out_cnt[m] < OW'(MAX_OUTSTANDING)) &&
                         ((out_cnt[m] == '0) || (last_bank[m] == BW'(b)));
         end
      end
   end

   always_comb begin : arb
      logic          found;
      int unsigned   idx;
      logic [MW-1:0] im;
      found = 1'b0;
      idx   = 0;
      im    = '0;
      for (int b = 0; b < N_BANKS; b++) begin
         winner[b] = '0;
         found     = 1'b0;
         for (int unsigned i = 0; i < NMASTERS; i++) begin
            idx = (32'(ptr[b]) + i) % NMASTERS;
            im  = MW'(idx);
            if (!found && elig[b][im]) begin
               found     = 1'b1;
               winner[b] = im;
            end
         end
         bank_req[b] = found;
         // A stalled request keeps its winner so addr/wdata stay stable until gnt.
         if (lock_valid[b] && master_req_i[lock_idx[b]].req) begin
            winner[b]   = lock_idx[b];
            bank_req[b] = 1'b1;
         end
         bank_hs[b] = bank_req[b] && ram_resp_i[b].gnt;
      end
   end

   always_comb begin
      m_gnt = '0;
      m_rv  = '0;
      for (int m = 0; m < NMASTERS; m++) begin
         master_resp_o[m] = '0;
      end
      for (int b = 0; b < N_BANKS; b++) begin
         ram_req_o[b] = '0;
         if (bank_req[b]) begin
            ram_req_o[b]     = master_req_i[winner[b]];
            ram_req_o[b].req = 1'b1;
         end
         if (bank_hs[b]) begin
            master_resp_o[winner[b]].gnt = 1'b1;
            m_gnt[winner[b]]             = 1'b1;
         end
         head[b]       = fifo_mem[b][rd_ptr[b]];
         fifo_empty[b] = (fifo_cnt[b] == '0);
         bank_rv[b]    = ram_resp_i[b].rvalid && !fifo_empty[b];
         if (bank_rv[b]) begin
            master_resp_o[head[b]].rvalid = 1'b1;
            master_resp_o[head[b]].rdata  = ram_resp_i[b].rdata;
            m_rv[head[b]]                 = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int m = 0; m < NMASTERS; m++) begin
            out_cnt[m]   <= '0;
            last_bank[m] <= '0;
         end
         for (int b = 0; b < N_BANKS; b++) begin
            ptr[b]      <= '0;
            lock_idx[b] <= '0;
            wr_ptr[b]   <= '0;
            rd_ptr[b]   <= '0;
            fifo_cnt[b] <= '0;
            for (int d = 0; d < FD; d++) begin
               fifo_mem[b][d] <= '0;
            end
         end
         lock_valid     <= '0;
         protocol_err_o <= 1'b0;
      end else begin
         for (int m = 0; m < NMASTERS; m++) begin
            if (m_gnt[m] && !m_rv[m]) begin
               out_cnt[m] <= out_cnt[m] + 1'b1;
            end else if (!m_gnt[m] && m_rv[m]) begin
               out_cnt[m] <= out_cnt[m] - 1'b1;
            end
            if (m_gnt[m]) begin
               last_bank[m] <= sel[m];
            end
         end
         for (int b = 0; b < N_BANKS; b++) begin
            if (bank_hs[b]) begin
               ptr[b]                 <= (winner[b] == MW'(NMASTERS - 1)) ? '0 : winner[b] + 1'b1;
               lock_valid[b]          <= 1'b0;
               fifo_mem[b][wr_ptr[b]] <= winner[b];
               wr_ptr[b]              <= (wr_ptr[b] == FW'(FD - 1)) ? '0 : wr_ptr[b] + 1'b1;
            end else begin
               lock_valid[b] <= bank_req[b];
               lock_idx[b]   <= winner[b];
            end
            if (bank_rv[b]) begin
               rd_ptr[b] <= (rd_ptr[b] == FW'(FD - 1)) ? '0 : rd_ptr[b] + 1'b1;
            end
            if (bank_hs[b] && !bank_rv[b]) begin
               fifo_cnt[b] <= fifo_cnt[b] + 1'b1;
            end else if (!bank_hs[b] && bank_rv[b]) begin
               fifo_cnt[b] <= fifo_cnt[b] - 1'b1;
            end
            if (ram_resp_i[b].rvalid && fifo_empty[b]) begin
               protocol_err_o <= 1'b1;
            end
         end
      end
   end

`ifdef MOCHILA_XBAR_PERF_EN
   logic [31:0] conflict_q [N_BANKS];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int b = 0; b < N_BANKS; b++) begin
            conflict_q[b] <= '0;
         end
      end else begin
         for (int b = 0; b < N_BANKS; b++) begin
            if (($countones(elig[b]) >= 2) && (conflict_q[b] != 32'hFFFF_FFFF)) begin
               conflict_q[b] <= conflict_q[b] + 32'd1;
            end
         end
      end
   end

   always_comb begin
      for (int b = 0; b < N_BANKS; b++) begin
         conflict_cnt_o[b] = conflict_q[b];
      end
   end
`else
   always_comb begin
      for (int b = 0; b < N_BANKS; b++) begin
         conflict_cnt_o[b] = '0;
      end
   end
`endif

endmodule

// File: tb/tb_obi_bank_xbar.sv
// tb/tb_obi_bank_xbar.sv - scoreboard bench for obi_bank_xbar (default and interleaved instances)
module tb_obi_bank_xbar;
   import obi_bank_xbar_pkg::*;

   localparam int NM = 4;
   localparam int NB = 2;
`ifdef MOCHILA_XBAR_PERF_EN
   localparam logic [31:0] CONF_EXP = 32'd10;
`else
   localparam logic [31:0] CONF_EXP = 32'd0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   obi_req_t    m_req  [NM];
   obi_resp_t   m_resp [NM];
   obi_req_t    r_req  [NB];
   obi_resp_t   r_resp [NB];
   logic        perr;
   logic [31:0] ccnt   [NB];

   obi_req_t    il_mreq  [1];
   obi_resp_t   il_mresp [1];
   obi_req_t    il_rreq  [4];
   obi_resp_t   il_rresp [4];
   logic        il_perr;
   logic [31:0] il_ccnt  [4];

   obi_bank_xbar u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .master_req_i(m_req), .master_resp_o(m_resp),
      .ram_req_o(r_req), .ram_resp_i(r_resp),
      .protocol_err_o(perr), .conflict_cnt_o(ccnt)
   );

   obi_bank_xbar #(.NMASTERS(1), .N_BANKS(4), .INTERLEAVED(1'b1)) u_il (
      .clk_i(clk), .rst_ni(rst_n),
      .master_req_i(il_mreq), .master_resp_o(il_mresp),
      .ram_req_o(il_rreq), .ram_resp_i(il_rresp),
      .protocol_err_o(il_perr), .conflict_cnt_o(il_ccnt)
   );

   int checks = 0;
   int passed = 0;
   int gnt_q[$];
   logic [33:0] rv_q[$];
   logic [NB-1:0] auto_rv;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   always @(negedge clk) begin : monitor
      int eg;
      logic [33:0] er;
      if (rst_n) begin
         for (int m = 0; m < NM; m++) begin
            if (m_resp[m].gnt) begin
               checks++;
               if (gnt_q.size() == 0) $display("FAIL gnt_unexpected: master %0d granted, none expected", m);
               else begin
                  eg = gnt_q.pop_front();
                  if (eg == m) passed++;
                  else $display("FAIL gnt_order: got master %0d expected master %0d", m, eg);
               end
            end
            if (m_resp[m].rvalid) begin
               checks++;
               if (rv_q.size() == 0) $display("FAIL rvalid_unexpected: master %0d rdata %h", m, m_resp[m].rdata);
               else begin
                  er = rv_q.pop_front();
                  if (er == {2'(m), m_resp[m].rdata}) passed++;
                  else $display("FAIL rvalid_route: got master %0d rdata %h expected master %0d rdata %h",
                                m, m_resp[m].rdata, er[33:32], er[31:0]);
               end
            end
         end
      end
   end

   task automatic exp_g(input int m);
      gnt_q.push_back(m);
   endtask

   task automatic exp_r(input int m, input logic [31:0] d);
      rv_q.push_back({2'(m), d});
   endtask

   task automatic mreq(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      m_req[m].req   = 1'b1;
      m_req[m].we    = we;
      m_req[m].be    = 4'hF;
      m_req[m].addr  = addr;
      m_req[m].wdata = wdata;
   endtask

   // Banks with auto_rv set answer every handshake one cycle later with rdata = ~addr.
   task automatic step();
      logic [NB-1:0] hs;
      logic [31:0]   ha [NB];
      @(negedge clk);
      for (int b = 0; b < NB; b++) begin
         hs[b] = r_req[b].req & r_resp[b].gnt;
         ha[b] = r_req[b].addr;
      end
      @(posedge clk);
      #1;
      check("gnt_pending", gnt_q.size(), 0);
      for (int b = 0; b < NB; b++) begin
         if (auto_rv[b]) begin
            r_resp[b].rvalid = hs[b];
            r_resp[b].rdata  = hs[b] ? ~ha[b] : 32'h0;
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int m = 0; m < NM; m++) m_req[m] = '0;
      for (int b = 0; b < NB; b++) r_resp[b] = '0;
      il_mreq[0] = '0;
      for (int b = 0; b < 4; b++) il_rresp[b] = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      auto_rv = '1;
      do_reset();
      rst_n = 1'b0;
      #2;
      for (int b = 0; b < NB; b++) begin
         check("rst_bank_req", r_req[b].req, 0);
         check("rst_bank_addr", r_req[b].addr, 0);
         check("rst_conflict", ccnt[b], 0);
      end
      for (int m = 0; m < NM; m++) begin
         check("rst_gnt", m_resp[m].gnt, 0);
         check("rst_rvalid", m_resp[m].rvalid, 0);
      end
      check("rst_perr", perr, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // single master read to bank 1, then outstanding must drain before bank 0
      r_resp[1].gnt = 1'b1;
      mreq(0, 1'b0, 32'h0000_8004, 32'h0);
      exp_g(0); exp_r(0, 32'hFFFF_7FFB);
      #2;
      check("t1_bank1_req", r_req[1].req, 1);
      check("t1_bank1_addr", r_req[1].addr, 32'h0000_8004);
      check("t1_bank0_idle", r_req[0].req, 0);
      step();
      mreq(0, 1'b0, 32'h0000_0010, 32'h0);
      r_resp[0].gnt = 1'b1;
      #2;
      check("t1_switch_stall", m_resp[0].gnt, 0);
      step();
      exp_g(0); exp_r(0, 32'hFFFF_FFEF);
      step();
      m_req[0] = '0;
      step();
      step();

      // round robin over four masters on bank 0
      do_reset();
      r_resp[0].gnt = 1'b1;
      r_resp[1].gnt = 1'b1;
      for (int m = 0; m < NM; m++) mreq(m, 1'b0, 32'(m) << 8, 32'h0);
      for (int k = 0; k < 5; k++) begin
         exp_g(k % NM);
         exp_r(k % NM, ~(32'(k % NM) << 8));
         step();
      end
      for (int m = 0; m < NM; m++) m_req[m] = '0;
      step();
      step();

      // stalled bank keeps winner and payload stable
      r_resp[0].gnt = 1'b0;
      mreq(1, 1'b1, 32'h0000_0040, 32'h1111_1111);
      mreq(2, 1'b1, 32'h0000_0080, 32'h2222_2222);
      for (int k = 0; k < 3; k++) begin
         #2;
         check("t3_req", r_req[0].req, 1);
         check("t3_addr", r_req[0].addr, 32'h0000_0040);
         check("t3_wdata", r_req[0].wdata, 32'h1111_1111);
         check("t3_we", r_req[0].we, 1);
         check("t3_m2_wait", m_resp[2].gnt, 0);
         step();
      end
      r_resp[0].gnt = 1'b1;
      exp_g(1); exp_r(1, 32'hFFFF_FFBF);
      step();
      m_req[1] = '0;
      exp_g(2); exp_r(2, 32'hFFFF_FF7F);
      step();
      m_req[2] = '0;
      step();
      step();

      // bank switch blocked by outstanding response
      auto_rv[0] = 1'b0;
      mreq(0, 1'b0, 32'h0000_0010, 32'h0);
      exp_g(0);
      step();
      mreq(0, 1'b0, 32'h0000_8010, 32'h0);
      step();
      step();
      r_resp[0].rvalid = 1'b1;
      r_resp[0].rdata  = 32'h0BAD_F00D;
      exp_r(0, 32'h0BAD_F00D);
      step();
      r_resp[0].rvalid = 1'b0;
      r_resp[0].rdata  = 32'h0;
      exp_g(0); exp_r(0, 32'hFFFF_7FEF);
      step();
      m_req[0] = '0;
      step();
      step();

      // MAX_OUTSTANDING=2: third request waits for the first response
      mreq(3, 1'b0, 32'h0000_0300, 32'h0);
      exp_g(3);
      step();
      mreq(3, 1'b0, 32'h0000_0304, 32'h0);
      exp_g(3);
      step();
      mreq(3, 1'b0, 32'h0000_0308, 32'h0);
      step();
      step();
      r_resp[0].rvalid = 1'b1;
      r_resp[0].rdata  = 32'hA000_0300;
      exp_r(3, 32'hA000_0300);
      step();
      r_resp[0].rdata  = 32'hA000_0304;
      exp_r(3, 32'hA000_0304);
      exp_g(3);
      step();
      m_req[3] = '0;
      r_resp[0].rdata  = 32'hA000_0308;
      exp_r(3, 32'hA000_0308);
      step();
      r_resp[0].rvalid = 1'b0;
      r_resp[0].rdata  = 32'h0;
      step();
      check("t4_no_perr", perr, 0);
      auto_rv[0] = 1'b1;

      // conflict counters
      do_reset();
      check("t6_rst_cnt0", ccnt[0], 0);
      check("t6_rst_cnt1", ccnt[1], 0);
      mreq(0, 1'b0, 32'h0000_8000, 32'h0);
      mreq(1, 1'b0, 32'h0000_8100, 32'h0);
      for (int k = 0; k < 10; k++) step();
      check("t6_conflict_bank1", ccnt[1], CONF_EXP);
      check("t6_conflict_bank0", ccnt[0], 0);
      m_req[0] = '0;
      m_req[1] = '0;
      step();

      // reset while a response is in flight
      auto_rv[0] = 1'b0;
      r_resp[0].gnt = 1'b1;
      mreq(0, 1'b0, 32'h0000_0020, 32'h0);
      exp_g(0);
      step();
      m_req[0] = '0;
      r_resp[0].gnt = 1'b0;
      #2;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      r_resp[0].rvalid = 1'b1;
      r_resp[0].rdata  = 32'h5555_AAAA;
      step();
      r_resp[0].rvalid = 1'b0;
      check("t7_perr_set", perr, 1);
      step();
      check("t7_perr_sticky", perr, 1);

      // interleaved mapping on the 1x4 instance
      for (int k = 0; k < 4; k++) begin
         il_mreq[0].req  = 1'b1;
         il_mreq[0].addr = 32'(k) << 2;
         #1;
         for (int b = 0; b < 4; b++) check("il_bank_sel", il_rreq[b].req, 32'(b == k));
      end
      il_mreq[0] = '0;
      check("il_perr_clear", il_perr, 0);
      il_rresp[2].rvalid = 1'b1;
      il_rresp[2].rdata  = 32'h1234_5678;
      #1;
      check("il_drop_rvalid", il_mresp[0].rvalid, 0);
      step();
      il_rresp[2] = '0;
      check("il_perr_set", il_perr, 1);
      step();
      step();
      check("il_perr_sticky", il_perr, 1);

      check("gnt_q_drained", gnt_q.size(), 0);
      check("rv_q_drained", rv_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
